// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back FIFO feeding the integer register-file
// write port. Two producers (ALU, MUL/DIV) push results over valid/ready. The
// queue retires at most one entry per cycle into a registered output stage and
// publishes a pending-destination bitmap for decode hazard stalls.
// Optional feature macro: WB_BYPASS_EN (a lone request into an idle queue loads
// straight into the output stage, for 1-cycle latency).
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ALU_VALID,
  input  logic [4:0]      ALU_RD,
  input  logic [XLEN-1:0] ALU_DATA,
  output logic            ALU_READY,
  input  logic            MD_VALID,
  input  logic [4:0]      MD_RD,
  input  logic [XLEN-1:0] MD_DATA,
  output logic            MD_READY,
  input  logic            WB_HOLD,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] RD_DATA,
  output logic            reg_write_enable,
  output logic [31:0]     PENDING,
  output logic            FULL,
  output logic            EMPTY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Queue storage and bookkeeping
  logic [4:0]      r_mem_rd   [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Output stage
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rd_data;
  logic            r_we;
  logic [31:0]     r_pending;

  // Handshake / push decode
  logic            w_free_ge1;
  logic            w_free_ge2;
  logic            w_alu_push;
  logic            w_md_push;
  logic            w_bypass;
  logic            w_alu_enq;
  logic            w_md_enq;
  logic            w_enq0;
  logic            w_enq1;
  logic [4:0]      w_slot0_rd;
  logic [XLEN-1:0] w_slot0_data;
  logic [PW-1:0]   w_wr_ptr1;
  logic            w_pop;
  logic [CW-1:0]   w_n_push;

  // Next-state values
  logic [4:0]       w_rd_next;
  logic [XLEN-1:0]  w_data_next;
  logic             w_we_next;
  logic [DEPTH-1:0] w_valid_next;
  logic [31:0]      w_pending_next;

  // Readiness depends only on the registered count, never on WB_HOLD.
  assign w_free_ge1 = (r_count < CW'(DEPTH));
  assign w_free_ge2 = (r_count <= CW'(DEPTH - 2));
  assign ALU_READY  = !RESET && w_free_ge1;
  assign MD_READY   = !RESET && (ALU_VALID ? w_free_ge2 : w_free_ge1);

  // x0 destinations complete the handshake but are dropped here.
  assign w_alu_push = ALU_VALID && ALU_READY && (ALU_RD != 5'd0);
  assign w_md_push  = MD_VALID  && MD_READY  && (MD_RD  != 5'd0);
  assign w_pop      = !WB_HOLD && (r_count != '0);

`ifdef WB_BYPASS_EN
  assign w_bypass = (r_count == '0) && !WB_HOLD && (w_alu_push || w_md_push);
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed ALU entry skips the FIFO; MD bypasses only when it is alone.
  assign w_alu_enq    = w_alu_push && !w_bypass;
  assign w_md_enq     = w_md_push && !(w_bypass && !w_alu_push);
  assign w_enq0       = w_alu_enq || w_md_enq;
  assign w_enq1       = w_alu_enq && w_md_enq;
  assign w_slot0_rd   = w_alu_enq ? ALU_RD   : MD_RD;
  assign w_slot0_data = w_alu_enq ? ALU_DATA : MD_DATA;
  assign w_wr_ptr1    = r_wr_ptr + PW'(1);
  assign w_n_push     = CW'(w_enq0) + CW'(w_enq1);

  // Next output stage and next pending bitmap, derived from the post-edge state.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
    w_we_next      = 1'b0;
    w_rd_next      = r_rd;
    w_data_next    = r_rd_data;
    w_valid_next   = r_valid;
    w_pending_next = '0;
    if (w_pop) begin
      w_we_next   = 1'b1;
      w_rd_next   = r_mem_rd[r_rd_ptr];
      w_data_next = r_mem_data[r_rd_ptr];
      w_valid_next[r_rd_ptr] = 1'b0;
    end else if (w_bypass) begin
      w_we_next   = 1'b1;
      w_rd_next   = w_alu_push ? ALU_RD   : MD_RD;
      w_data_next = w_alu_push ? ALU_DATA : MD_DATA;
    end
    if (w_enq0) w_valid_next[r_wr_ptr]  = 1'b1;
    if (w_enq1) w_valid_next[w_wr_ptr1] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid_next[i]) begin
        if (w_enq0 && (PW'(i) == r_wr_ptr))
          w_pending_next[w_slot0_rd] = 1'b1;
        else if (w_enq1 && (PW'(i) == w_wr_ptr1))
          w_pending_next[MD_RD] = 1'b1;
        else
          w_pending_next[r_mem_rd[i]] = 1'b1;
      end
    end
    if (w_we_next) w_pending_next[w_rd_next] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  // FIFO payload writes; ALU lands ahead of MD when both are enqueued.
  // NOTE: payload storage is not reset; r_valid and r_count alone decide which slots are meaningful.
  always_ff @(posedge CLK) begin
    if (w_enq0) begin
      r_mem_rd[r_wr_ptr]   <= w_slot0_rd;
      r_mem_data[r_wr_ptr] <= w_slot0_data;
    end
    if (w_enq1) begin
      r_mem_rd[w_wr_ptr1]   <= MD_RD;
      r_mem_data[w_wr_ptr1] <= MD_DATA;
    end
  end

  // Pointers, count, occupancy bits, output stage and pending bitmap.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_rd      <= '0;
      r_rd_data <= '0;
      r_we      <= 1'b0;
      r_pending <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + PW'(w_n_push);
      r_rd_ptr  <= r_rd_ptr + PW'(w_pop);
      r_count   <= r_count + w_n_push - CW'(w_pop);
      r_valid   <= w_valid_next;
      r_rd      <= w_rd_next;
      r_rd_data <= w_data_next;
      r_we      <= w_we_next;
      r_pending <= w_pending_next;
    end
  end

  assign RD               = r_rd;
  assign RD_DATA          = r_rd_data;
  assign reg_write_enable = r_we;
  assign PENDING          = r_pending;
  assign FULL             = (r_count == CW'(DEPTH));
  assign EMPTY            = (r_count == '0);

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue (default build, DEPTH=4, XLEN=64).
// Each table row is one clock cycle: inputs driven after the falling edge,
// ready outputs checked before the rising edge, registered outputs after it.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [63:0] md_data;
  logic        md_ready;
  logic        wb_hold;
  logic [4:0]  rd;
  logic [63:0] rd_data;
  logic        we;
  logic [31:0] pending;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(4), .XLEN(64)) dut (
    .CLK              (clk),
    .RESET            (rst),
    .ALU_VALID        (alu_valid),
    .ALU_RD           (alu_rd),
    .ALU_DATA         (alu_data),
    .ALU_READY        (alu_ready),
    .MD_VALID         (md_valid),
    .MD_RD            (md_rd),
    .MD_DATA          (md_data),
    .MD_READY         (md_ready),
    .WB_HOLD          (wb_hold),
    .RD               (rd),
    .RD_DATA          (rd_data),
    .reg_write_enable (we),
    .PENDING          (pending),
    .FULL             (full),
    .EMPTY            (empty)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic        av;
    logic [4:0]  ard;
    logic [63:0] adata;
    logic        mv;
    logic [4:0]  mrd;
    logic [63:0] mdata;
    logic        e_ardy;
    logic        e_mrdy;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic        e_we;
    logic [31:0] e_pend;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic h, logic av, logic [4:0] ard, logic [63:0] ad,
                              logic mv, logic [4:0] mrd, logic [63:0] md,
                              logic ardy, logic mrdy, logic [4:0] erd, logic [63:0] ed,
                              logic ewe, logic [31:0] ep, logic ef, logic ee);
    vec_t v;
    v.rst = r;  v.hold = h;  v.av = av; v.ard = ard; v.adata = ad;
    v.mv = mv;  v.mrd = mrd; v.mdata = md;
    v.e_ardy = ardy; v.e_mrdy = mrdy; v.e_rd = erd; v.e_data = ed;
    v.e_we = ewe; v.e_pend = ep; v.e_full = ef; v.e_empty = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; wb_hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    md_valid  = 1'b0; md_rd  = '0; md_data  = '0;
  endtask

  initial begin
    int lat;
    int strobes;
    drive_idle();

    //  rst hold  ALU(v,rd,data)       MD(v,rd,data)             ardy mrdy  RD  RD_DATA        we  PENDING        full empty
    add(1, 0,  0,  0, 64'h0,       0,  0, 64'h0,           0, 0,   0, 64'h0,         0, 32'h0,         0, 1); // reset
    // single ALU write, 2-cycle latency
    add(0, 0,  1,  1, 64'd5,       0,  0, 64'h0,           1, 1,   0, 64'h0,         0, 32'h2,         0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   1, 64'd5,         1, 32'h2,         0, 1);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   1, 64'd5,         0, 32'h0,         0, 1);
    // dual push: ALU ahead of MD
    add(0, 0,  1,  2, 64'd10,      1,  3, 64'hDEAD_BEEF,   1, 1,   1, 64'd5,         0, 32'hC,         0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   2, 64'd10,        1, 32'hC,         0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   3, 64'hDEAD_BEEF, 1, 32'h8,         0, 1);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   3, 64'hDEAD_BEEF, 0, 32'h0,         0, 1);
    // fill under hold, one free slot admits only ALU, then drain in order
    add(0, 1,  1,  4, 64'd4,       1,  5, 64'd5,           1, 1,   3, 64'hDEAD_BEEF, 0, 32'h30,        0, 0);
    add(0, 1,  1,  6, 64'd6,       1,  7, 64'd7,           1, 1,   3, 64'hDEAD_BEEF, 0, 32'hF0,        1, 0);
    add(0, 1,  1,  8, 64'd8,       1,  9, 64'd9,           0, 0,   3, 64'hDEAD_BEEF, 0, 32'hF0,        1, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           0, 0,   4, 64'd4,         1, 32'hF0,        0, 0);
    add(0, 1,  1,  8, 64'd8,       1,  9, 64'd9,           1, 0,   4, 64'd4,         0, 32'h1E0,       1, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           0, 0,   5, 64'd5,         1, 32'h1E0,       0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   6, 64'd6,         1, 32'h1C0,       0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   7, 64'd7,         1, 32'h180,       0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   8, 64'd8,         1, 32'h100,       0, 1);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   8, 64'd8,         0, 32'h0,         0, 1);
    // x0 destinations are handshaken and dropped
    add(0, 0,  1,  0, 64'd99,      0,  0, 64'h0,           1, 1,   8, 64'd8,         0, 32'h0,         0, 1);
    add(0, 0,  0,  0, 64'h0,       1,  0, 64'd7,           1, 1,   8, 64'd8,         0, 32'h0,         0, 1);
    // MD-only write to x31
    add(0, 0,  0,  0, 64'h0,       1, 31, 64'h123,         1, 1,   8, 64'd8,         0, 32'h8000_0000, 0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,  31, 64'h123,       1, 32'h8000_0000, 0, 1);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,  31, 64'h123,       0, 32'h0,         0, 1);
    // full with pop: ALU refused, then accepted alongside the next pop
    add(0, 1,  1, 10, 64'hA0,      1, 11, 64'hB0,          1, 1,  31, 64'h123,       0, 32'hC00,       0, 0);
    add(0, 1,  1, 12, 64'hC0,      1, 13, 64'hD0,          1, 1,  31, 64'h123,       0, 32'h3C00,      1, 0);
    add(0, 0,  1, 14, 64'hE0,      0,  0, 64'h0,           0, 0,  10, 64'hA0,        1, 32'h3C00,      0, 0);
    add(0, 0,  1, 14, 64'hE0,      0,  0, 64'h0,           1, 0,  11, 64'hB0,        1, 32'h7800,      0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,  12, 64'hC0,        1, 32'h7000,      0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,  13, 64'hD0,        1, 32'h6000,      0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,  14, 64'hE0,        1, 32'h4000,      0, 1);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,  14, 64'hE0,        0, 32'h0,         0, 1);
    // reset with an entry queued and one in the output stage
    add(0, 1,  1, 15, 64'd1,       1, 16, 64'd2,           1, 1,  14, 64'hE0,        0, 32'h18000,     0, 0);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,  15, 64'd1,         1, 32'h18000,     0, 0);
    add(1, 0,  1, 17, 64'd3,       0,  0, 64'h0,           0, 0,   0, 64'h0,         0, 32'h0,         0, 1);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   0, 64'h0,         0, 32'h0,         0, 1);
    add(0, 0,  0,  0, 64'h0,       0,  0, 64'h0,           1, 1,   0, 64'h0,         0, 32'h0,         0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; wb_hold = vecs[i].hold;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
      md_valid  = vecs[i].mv; md_rd  = vecs[i].mrd; md_data  = vecs[i].mdata;
      #1;
      check($sformatf("v%0d ALU_READY", i), 64'(alu_ready), 64'(vecs[i].e_ardy));
      check($sformatf("v%0d MD_READY", i),  64'(md_ready),  64'(vecs[i].e_mrdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d RD", i),        64'(rd),      64'(vecs[i].e_rd));
      check($sformatf("v%0d RD_DATA", i),   rd_data,      vecs[i].e_data);
      check($sformatf("v%0d WE", i),        64'(we),      64'(vecs[i].e_we));
      check($sformatf("v%0d PENDING", i),   64'(pending), 64'(vecs[i].e_pend));
      check($sformatf("v%0d FULL", i),      64'(full),    64'(vecs[i].e_full));
      check($sformatf("v%0d EMPTY", i),     64'(empty),   64'(vecs[i].e_empty));
      @(negedge clk);
    end

    // Latency and single-strobe sequence: one ALU write to x20, bounded watch.
    drive_idle();
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'h55;
    @(posedge clk);
    #1;
    drive_idle();
    lat = 0;
    strobes = 0;
    if (we) begin
      lat = 1;
      strobes++;
    end
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (we) begin
        strobes++;
        if (lat == 0) lat = k;
        check("seq RD at strobe", 64'(rd), 64'd20);
        check("seq RD_DATA at strobe", rd_data, 64'h55);
      end
    end
    check("seq latency edges", 64'(lat), 64'd2);
    check("seq strobe count", 64'(strobes), 64'd1);
    check("seq PENDING after", 64'(pending), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
